// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// lookahead group size and the iteration-counter width helper.
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_e;

   localparam int unsigned CLA_GROUP = 4;

   function automatic int unsigned f_cnt_w(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// Combinational W-bit subtractor a - b computed as a + ~b + 1, with carries
// resolved by group generate/propagate lookahead.
module seq_restoring_divider_cla_subtractor
   import seq_restoring_divider_pkg::*;
#(
   parameter int unsigned W = 9
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_diff,
   output logic         o_borrow
);

   logic [W-1:0] w_g;
   logic [W-1:0] w_p;

   assign w_g = i_a & ~i_b;
   assign w_p = i_a ^ ~i_b;

   // Each carry is formed from the generate/propagate terms of its own group
   // plus that group's carry-in.
   always_comb begin : p_carry
      logic [W:0] c;
      logic       gg;
      logic       gp;
      c    = '0;
      c[0] = 1'b1;
      gg   = 1'b0;
      gp   = 1'b1;
      for (int unsigned i = 0; i < W; i++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int unsigned j = (i / CLA_GROUP) * CLA_GROUP; j <= i; j++) begin
            gg = w_g[j] | (w_p[j] & gg);
            gp = gp & w_p[j];
         end
         c[i+1] = gg | (gp & c[(i / CLA_GROUP) * CLA_GROUP]);
      end
      o_diff   = w_p ^ c[W-1:0];
      o_borrow = ~c[W];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock with a
// start/busy/done handshake.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = f_cnt_w(WIDTH);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_d;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_t;
   logic             w_unused_borrow;
   logic             w_take;
   logic [WIDTH-1:0] w_r_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_last;
   logic             w_zero;

   assign w_s = {r_r, r_q[WIDTH-1]};

   seq_restoring_divider_cla_subtractor #(
      .W(WIDTH + 1)
   ) u_cla_subtractor (
      .i_a      (w_s),
      .i_b      ({1'b0, r_d}),
      .o_diff   (w_t),
      .o_borrow (w_unused_borrow)
   );

   // R stays below the divisor, so its top bit is always zero and is not stored.
   assign w_take  = ~w_t[WIDTH];
   assign w_r_nxt = w_take ? w_t[WIDTH-1:0] : w_s[WIDTH-1:0];
   assign w_q_nxt = {r_q[WIDTH-2:0], w_take};
   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_zero  = (r_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // A zero divisor resolves on the first CALC edge without iterating.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = CALC;
         CALC:    if (w_zero || w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state != IDLE);
      done        = (r_state == DONE);
      quotient    = r_quotient;
      remainder   = r_remainder;
      div_by_zero = r_dbz;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         r_r         <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_q   <= dividend;
                  r_d   <= divisor;
                  r_r   <= '0;
                  r_cnt <= '0;
               end
            end
            CALC: begin
               if (w_zero) begin
                  r_quotient  <= '1;
                  r_remainder <= r_q;
                  r_dbz       <= 1'b1;
               end else begin
                  r_q   <= w_q_nxt;
                  r_r   <= w_r_nxt;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_quotient  <= w_q_nxt;
                     r_remainder <= w_r_nxt;
                     r_dbz       <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised self-checking bench for seq_restoring_divider against a
// cycle-level arithmetic model of the handshake and results.
module tb_seq_restoring_divider;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   seq_restoring_divider #(
      .WIDTH(W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model state: an accepted operation finishes at a known cycle with results
   // given by integer division; results are held until the next completion.
   int unsigned  cyc = 0;
   bit           m_busy = 0;
   int unsigned  m_done_at = 0;
   int unsigned  op_dd = 0;
   int unsigned  op_dv = 0;
   logic [W-1:0] mq = '0, mr = '0, pq = '0, pr = '0;
   logic         mz = 1'b0, pz = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_busy = 0;
            mq = '0; mr = '0; mz = 1'b0;
         end else begin
            cyc++;
            if (m_busy && cyc == m_done_at) begin
               mq = pq; mr = pr; mz = pz;
            end
            if (m_busy && cyc == m_done_at + 1) begin
               m_busy = 0;
            end else if (!m_busy && start) begin
               m_busy = 1;
               op_dd  = dividend;
               op_dv  = divisor;
               if (op_dv == 0) begin
                  m_done_at = cyc + 1;
                  pq = '1; pr = W'(op_dd); pz = 1'b1;
               end else begin
                  m_done_at = cyc + W;
                  pq = W'(op_dd / op_dv); pr = W'(op_dd % op_dv); pz = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("busy", busy, m_busy);
            chk("done", done, (m_busy && cyc == m_done_at));
            chk("quotient", quotient, mq);
            chk("remainder", remainder, mr);
            chk("div_by_zero", div_by_zero, mz);
            if (done === 1'b1 && op_dv != 0) begin
               chk("inv_sum", longint'(quotient) * op_dv + remainder, op_dd);
               chk("inv_rem_lt_div", (remainder < op_dv), 1);
            end
         end
      end
   end

   task automatic do_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
      @(negedge clk);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return '1;
         2:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      logic [W-1:0] dd, dv;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;

      do_op(8'd100, 8'd7);
      chk("busy_after_accept", busy, 1);
      wait_done(1, lat);
      chk("lat_100_7", lat, 9);
      chk("q_100_7", quotient, 14);
      chk("r_100_7", remainder, 2);
      chk("dbz_100_7", div_by_zero, 0);

      do_op(8'd255, 8'd1);
      wait_done(1, lat);
      chk("q_255_1", quotient, 255);
      chk("r_255_1", remainder, 0);
      do_op(8'd5, 8'd9);
      wait_done(1, lat);
      chk("lat_5_9", lat, 9);
      chk("q_5_9", quotient, 0);
      chk("r_5_9", remainder, 5);

      do_op(8'd200, 8'd0);
      wait_done(1, lat);
      chk("lat_200_0", lat, 2);
      chk("q_200_0", quotient, 8'hFF);
      chk("r_200_0", remainder, 200);
      chk("dbz_200_0", div_by_zero, 1);
      do_op(8'd9, 8'd3);
      wait_done(1, lat);
      chk("q_9_3", quotient, 3);
      chk("r_9_3", remainder, 0);
      chk("dbz_9_3", div_by_zero, 0);

      do_op(8'd100, 8'd7);
      repeat (2) @(negedge clk);
      start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, lat);
      chk("lat_ignore", lat, 9);
      chk("q_ignore", quotient, 14);
      chk("r_ignore", remainder, 2);
      start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", busy, 0);
      repeat (3) @(negedge clk);
      chk("no_second_done_q", quotient, 14);

      do_op(8'd170, 8'd13);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_op(8'd170, 8'd13);
      wait_done(1, lat);
      chk("q_170_13", quotient, 13);
      chk("r_170_13", remainder, 1);

      for (int k = 0; k < 2000; k++) begin
         dd = pick();
         dv = pick();
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(dd, dv);
         wait_done(1, lat);
         chk("lat_rand", lat, (dv == 0) ? 2 : W + 1);
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
